// File: rtl/sflash_ctrl.sv
// sflash_ctrl: byte-oriented serial-flash master (single / dual / quad).
// One host byte per wr strobe. Each byte is shifted out MSB-first on qdo
// and the same number of beats is shifted in from qdi. sclk idles high
// (SPI mode 3). Pad data is sampled at each beat-start falling edge.
// Optional feature macro: SFLASH_QUAD_EN enables dual/quad formats 4-7.
// Without it, formats 4-7 act as format 2 and only the 1-bit shifter exists.
module sflash_ctrl (
  input  logic       clk,
  input  logic       arstn,
  output logic       ready,
  input  logic       wr,
  input  logic       who,
  input  logic [7:0] din,
  input  logic [2:0] format,
  input  logic [3:0] prescale,
  output logic [7:0] dout,
  output logic       sclk,
  output logic       cs_n,
  input  logic [3:0] qdi,
  output logic [3:0] qdo,
  output logic [3:0] oe
);

  typedef enum logic [2:0] {
    ST_IDLE,   // waiting for wr
    ST_START,  // decide: deselect, open frame, or first beat
    ST_DESEL,  // cs_n high for 2P on requester change
    ST_SETUP,  // cs_n low, sclk high for P before first beat
    ST_LOW,    // sclk low phase of a beat
    ST_HIGH,   // sclk high phase of a beat
    ST_TAIL    // cs_n released, 2P before ready
  } state_t;

  state_t     state, state_nx;
  logic [4:0] cnt, cnt_nx;
  logic [3:0] beat;
  logic       owner;

  // Byte context captured with wr; data path, so no reset needed.
  logic [7:0] tx, rx;
  logic [2:0] fmt_l;
  logic [3:0] pre_l;
  logic       who_l;

  logic [4:0] p_m1, two_p_m1;
  logic       hold;
  logic [3:0] oe_val, last_beat;
  logic [3:0] tx_bits;
  logic [7:0] tx_shift, rx_shift;

  logic do_latch, do_desel, do_open, do_fall, do_rise, do_end, do_done;

  // Half period P = prescale+1, so P-1 = prescale and 2P-1 = 2*prescale+1.
  assign p_m1     = {1'b0, pre_l};
  assign two_p_m1 = {pre_l, 1'b1};
  assign hold     = fmt_l[2] | fmt_l[1];

`ifdef SFLASH_QUAD_EN
  logic [1:0] mode;  // 0 single, 1 dual, 2 quad

  // Decode latched format into lane width, pad enables and beat count.
  always_comb begin
    mode      = 2'd0;
    oe_val    = 4'b0001;
    last_beat = 4'd8;
    case (fmt_l)
      3'd4: begin mode = 2'd1; oe_val = 4'b0011; last_beat = 4'd4; end
      3'd5: begin mode = 2'd1; oe_val = 4'b0000; last_beat = 4'd4; end
      3'd6: begin mode = 2'd2; oe_val = 4'b1111; last_beat = 4'd2; end
      3'd7: begin mode = 2'd2; oe_val = 4'b0000; last_beat = 4'd2; end
      default: ;
    endcase
  end

  // Per-beat bits to drive and next shift-register values for each width.
  always_comb begin
    tx_bits  = {3'b000, tx[7]};
    tx_shift = {tx[6:0], 1'b0};
    rx_shift = {rx[6:0], qdi[1]};
    case (mode)
      2'd1: begin
        tx_bits  = {2'b00, tx[7:6]};
        tx_shift = {tx[5:0], 2'b00};
        rx_shift = {rx[5:0], qdi[1:0]};
      end
      2'd2: begin
        tx_bits  = tx[7:4];
        tx_shift = {tx[3:0], 4'b0000};
        rx_shift = {rx[3:0], qdi};
      end
      default: ;
    endcase
  end
`else
  logic unused_bits;

  assign oe_val      = 4'b0001;
  assign last_beat   = 4'd8;
  assign unused_bits = ^{qdi[3:2], qdi[0], fmt_l[0]};

  // Single-lane shifter only: one bit out on qdo[0], one bit in from qdi[1].
  always_comb begin
    tx_bits  = {3'b000, tx[7]};
    tx_shift = {tx[6:0], 1'b0};
    rx_shift = {rx[6:0], qdi[1]};
  end
`endif

  // State and phase-counter register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state <= ST_IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic and one-cycle action strobes for the register blocks.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    do_latch = 1'b0;
    do_desel = 1'b0;
    do_open  = 1'b0;
    do_fall  = 1'b0;
    do_rise  = 1'b0;
    do_end   = 1'b0;
    do_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr) begin
          do_latch = 1'b1;
          state_nx = ST_START;
        end
      end
      ST_START: begin
        if (!cs_n && (who_l != owner)) begin
          do_desel = 1'b1;
          cnt_nx   = two_p_m1;
          state_nx = ST_DESEL;
        end else if (cs_n) begin
          do_open  = 1'b1;
          cnt_nx   = p_m1;
          state_nx = ST_SETUP;
        end else begin
          do_fall  = 1'b1;
          cnt_nx   = p_m1;
          state_nx = ST_LOW;
        end
      end
      ST_DESEL: begin
        if (cnt == 5'd0) begin
          do_open  = 1'b1;
          cnt_nx   = p_m1;
          state_nx = ST_SETUP;
        end else begin
          cnt_nx = cnt - 5'd1;
        end
      end
      ST_SETUP: begin
        if (cnt == 5'd0) begin
          do_fall  = 1'b1;
          cnt_nx   = p_m1;
          state_nx = ST_LOW;
        end else begin
          cnt_nx = cnt - 5'd1;
        end
      end
      ST_LOW: begin
        if (cnt == 5'd0) begin
          do_rise  = 1'b1;
          cnt_nx   = p_m1;
          state_nx = ST_HIGH;
        end else begin
          cnt_nx = cnt - 5'd1;
        end
      end
      ST_HIGH: begin
        if (cnt == 5'd0) begin
          if (beat == last_beat) begin
            do_end = 1'b1;
            if (hold) begin
              state_nx = ST_IDLE;
            end else begin
              cnt_nx   = two_p_m1;
              state_nx = ST_TAIL;
            end
          end else begin
            do_fall  = 1'b1;
            cnt_nx   = p_m1;
            state_nx = ST_LOW;
          end
        end else begin
          cnt_nx = cnt - 5'd1;
        end
      end
      ST_TAIL: begin
        if (cnt == 5'd0) begin
          do_done  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt - 5'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Latch the byte context on wr and shift both directions on each fall.
  always_ff @(posedge clk) begin
    if (do_latch) begin
      tx    <= din;
      fmt_l <= format;
      pre_l <= prescale;
      who_l <= who;
    end else if (do_fall) begin
      tx <= tx_shift;
      rx <= rx_shift;
    end
  end

  // Pad-facing outputs, handshake and frame ownership.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ready <= 1'b1;
      dout  <= 8'h00;
      sclk  <= 1'b1;
      cs_n  <= 1'b1;
      qdo   <= 4'h0;
      oe    <= 4'h0;
      owner <= 1'b0;
      beat  <= 4'd0;
    end else begin
      if (do_latch) ready <= 1'b0;
      if (do_desel) cs_n <= 1'b1;
      if (do_open) begin
        cs_n  <= 1'b0;
        owner <= who_l;
      end
      if (do_fall) begin
        sclk <= 1'b0;
        qdo  <= tx_bits;
        oe   <= oe_val;
        beat <= beat + 4'd1;
      end
      if (do_rise) sclk <= 1'b1;
      if (do_end) begin
        qdo  <= 4'h0;
        dout <= rx;
        beat <= 4'd0;
        if (hold) begin
          ready <= 1'b1;
        end else begin
          cs_n <= 1'b1;
          oe   <= 4'h0;
        end
      end
      if (do_done) ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sflash_ctrl.sv
// tb_sflash_ctrl: directed loopback vectors for sflash_ctrl.
// The pads are looped back (single: qdi[1]=qdo[0]; dual/quad: qdi=qdo) and
// each byte's dout, sclk pulse count, low-phase length, lead-in, cs_n
// framing and oe are compared against hand-computed values.
module tb_sflash_ctrl;

  logic       clk;
  logic       arstn;
  logic       ready;
  logic       wr;
  logic       who;
  logic [7:0] din;
  logic [2:0] format;
  logic [3:0] prescale;
  logic [7:0] dout;
  logic       sclk;
  logic       cs_n;
  logic [3:0] qdi;
  logic [3:0] qdo;
  logic [3:0] oe;
  logic       lb_single;

  int n_vec;
  int n_miss;

  sflash_ctrl dut (
    .clk      (clk),
    .arstn    (arstn),
    .ready    (ready),
    .wr       (wr),
    .who      (who),
    .din      (din),
    .format   (format),
    .prescale (prescale),
    .dout     (dout),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .qdi      (qdi),
    .qdo      (qdo),
    .oe       (oe)
  );

  assign qdi = lb_single ? {2'b00, qdo[0], 1'b0} : qdo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts at a negedge with ready=1; returns at the negedge where ready=1 again.
  task automatic send_byte(input logic [7:0] d, input logic [2:0] f,
                           input logic [3:0] p, input logic w, input logic slb,
                           input int glitch_at,
                           output logic [7:0] got, output int pulses,
                           output int lows, output int lead, output int cs_hi,
                           output logic [3:0] oe_seen, output logic cs_end);
    logic prev_sclk;
    bit   fell;
    int   cyc;
    lb_single = slb;
    din = d; format = f; prescale = p; who = w; wr = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    pulses = 0; lows = 0; lead = 0; cs_hi = 0; oe_seen = 4'h0;
    prev_sclk = 1'b1; fell = 1'b0; cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (ready) break;
      if (!sclk && prev_sclk) begin
        pulses++;
        if (!fell) begin
          lead = cyc - 1;
          fell = 1'b1;
        end
      end
      if (!sclk) begin
        lows++;
        oe_seen = oe;
      end
      if (cs_n) cs_hi++;
      prev_sclk = sclk;
      if (cyc == glitch_at) begin
        din = 8'hFF;
        wr  = 1'b1;
      end else if (cyc == glitch_at + 1) begin
        wr = 1'b0;
      end
    end
    wr = 1'b0;
    check_eq("ready_in_budget", int'(ready), 1);
    got    = dout;
    cs_end = cs_n;
  endtask

  task automatic run_case(input string name, input logic [7:0] d,
                          input logic [2:0] f, input logic [3:0] p,
                          input logic w, input logic slb, input int glitch_at,
                          input logic [7:0] e_dout, input int e_pulses,
                          input int e_lows, input int e_lead, input int e_cshi,
                          input logic [3:0] e_oe, input logic e_csend);
    logic [7:0] got;
    logic [3:0] oe_seen;
    logic       cs_end;
    int         pulses, lows, lead, cs_hi;
    send_byte(d, f, p, w, slb, glitch_at, got, pulses, lows, lead, cs_hi, oe_seen, cs_end);
    check_eq({name, ".dout"},   int'(got), int'(e_dout));
    check_eq({name, ".pulses"}, pulses, e_pulses);
    check_eq({name, ".lows"},   lows, e_lows);
    check_eq({name, ".lead"},   lead, e_lead);
    check_eq({name, ".cs_hi"},  cs_hi, e_cshi);
    check_eq({name, ".oe"},     int'(oe_seen), int'(e_oe));
    check_eq({name, ".cs_end"}, int'(cs_end), int'(e_csend));
    check_eq({name, ".qdo0"},   int'(qdo), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, ".ready"}, int'(ready), 1);
    check_eq({name, ".dout"},  int'(dout), 0);
    check_eq({name, ".sclk"},  int'(sclk), 1);
    check_eq({name, ".cs_n"},  int'(cs_n), 1);
    check_eq({name, ".qdo"},   int'(qdo), 0);
    check_eq({name, ".oe"},    int'(oe), 0);
  endtask

  // Watch the bus while idle: no sclk activity, ready stays high.
  task automatic check_quiet(input string name, input int ncyc);
    int lows, busy;
    lows = 0; busy = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (!sclk) lows++;
      if (!ready) busy++;
    end
    check_eq({name, ".sclk_low"}, lows, 0);
    check_eq({name, ".busy"}, busy, 0);
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    arstn = 1'b0; wr = 1'b0; who = 1'b0; din = 8'h00;
    format = 3'd0; prescale = 4'd0; lb_single = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    arstn = 1'b1;
    @(negedge clk);

    // name, din, fmt, pre, who, single_lb, glitch, dout, pulses, lows, lead, cs_hi, oe, cs_end
    run_case("single_f2", 8'h12, 3'd2, 4'd0, 1'b0, 1'b1, 0, 8'h09, 8, 8, 2, 1, 4'b0001, 1'b0);
`ifdef SFLASH_QUAD_EN
    run_case("dual_wr",   8'h34, 3'd4, 4'd0, 1'b0, 1'b0, 0, 8'h0D, 4, 4, 1, 0, 4'b0011, 1'b0);
    run_case("quad_wr",   8'h56, 3'd6, 4'd0, 1'b0, 1'b0, 0, 8'h05, 2, 2, 1, 0, 4'b1111, 1'b0);
`else
    run_case("dual_wr",   8'h34, 3'd4, 4'd0, 1'b0, 1'b1, 0, 8'h1A, 8, 8, 1, 0, 4'b0001, 1'b0);
    run_case("quad_wr",   8'h56, 3'd6, 4'd0, 1'b0, 1'b1, 0, 8'h2B, 8, 8, 1, 0, 4'b0001, 1'b0);
`endif
    run_case("single_f0", 8'h78, 3'd0, 4'd0, 1'b0, 1'b1, 0, 8'h3C, 8, 8, 1, 2, 4'b0001, 1'b1);
    run_case("pre1",      8'h99, 3'd2, 4'd1, 1'b0, 1'b1, 0, 8'h4C, 8, 16, 3, 1, 4'b0001, 1'b0);
    run_case("owner_chg", 8'hA5, 3'd0, 4'd0, 1'b1, 1'b1, 0, 8'h52, 8, 8, 4, 4, 4'b0001, 1'b1);
`ifdef SFLASH_QUAD_EN
    run_case("quad_rd",   8'hC3, 3'd7, 4'd0, 1'b1, 1'b0, 0, 8'h0C, 2, 2, 2, 1, 4'b0000, 1'b0);
`else
    run_case("quad_rd",   8'hC3, 3'd7, 4'd0, 1'b1, 1'b1, 0, 8'h61, 8, 8, 2, 1, 4'b0001, 1'b0);
`endif
    run_case("wr_busy",   8'h12, 3'd2, 4'd0, 1'b1, 1'b1, 5, 8'h09, 8, 8, 1, 0, 4'b0001, 1'b0);
    check_quiet("after_busy_wr", 12);
    check_eq("after_busy_wr.dout", int'(dout), 8'h09);

    // Mid-byte asynchronous reset.
    lb_single = 1'b1;
    din = 8'h55; format = 3'd2; prescale = 4'd0; who = 1'b1; wr = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("midbyte.busy", int'(ready), 0);
    #2 arstn = 1'b0;
    #1 check_reset_outputs("midbyte_rst");
    @(negedge clk);
    arstn = 1'b1;
    check_quiet("post_rst", 8);
    check_eq("post_rst.cs_n", int'(cs_n), 1);

    run_case("after_rst", 8'hA5, 3'd0, 4'd0, 1'b0, 1'b1, 0, 8'h52, 8, 8, 2, 3, 4'b0001, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
